// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 select + skid output stage.
package mux_pkg;

  localparam int unsigned MinNumIn = 2;
  localparam int unsigned DefWidth = 5;
  localparam int unsigned DefNumIn = 4;

  // Constant-evaluable ceil(log2(n)); 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 1) ? n - 1 : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int unsigned DefSelW = clog2(DefNumIn);

  // Entry layout for the default 4:1 x 5-bit configuration; mux_n_skid mirrors it at its widths.
  typedef struct packed {
    logic [DefWidth-1:0] data;
    logic [DefSelW-1:0]  sel;
    logic                err;
  } entry_t;

  function automatic int unsigned entry_w(input int unsigned width, input int unsigned sel_w);
    return width + sel_w + 1;
  endfunction

endpackage

// File: rtl/skid_buf.sv
// Generic 2-entry valid/ready stage: main register M drives the outputs, skid register S
// absorbs one extra beat so in_ready comes straight from a flop.
module skid_buf #(
  parameter int unsigned ENTRY_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ENTRY_W-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [ENTRY_W-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [ENTRY_W-1:0] m_q, m_d, s_q, s_d;
  logic               m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic               acc, pop;

  assign in_ready  = ~s_valid_q;
  assign out_data  = m_q;
  assign out_valid = m_valid_q;

  assign acc = in_valid & in_ready;
  assign pop = m_valid_q & out_ready;

  always_comb begin
    m_d       = m_q;
    m_valid_d = m_valid_q;
    s_d       = s_q;
    s_valid_d = s_valid_q;
    if (flush) begin
      // Data in M is left untouched so out_data keeps its last value.
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || pop) begin
      if (s_valid_q) begin
        m_d       = s_q;
        m_valid_d = 1'b1;
        s_valid_d = 1'b0;
        if (acc) begin
          s_d       = in_data;
          s_valid_d = 1'b1;
        end
      end else if (acc) begin
        m_d       = in_data;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (acc) begin
      s_d       = in_data;
      s_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q       <= '0;
      m_valid_q <= 1'b0;
      s_q       <= '0;
      s_valid_q <= 1'b0;
    end else begin
      m_q       <= m_d;
      m_valid_q <= m_valid_d;
      s_q       <= s_d;
      s_valid_q <= s_valid_d;
    end
  end

  a_skid_implies_main: assert property (@(posedge clk) disable iff (!rst_n)
    s_valid_q |-> m_valid_q);

  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (m_valid_q && !out_ready && !flush) |=> (m_valid_q && $stable(m_q)));

endmodule

// File: rtl/mux_n_skid.sv
// N-input, WIDTH-bit selector feeding a registered 2-entry skid output stage.
module mux_n_skid
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH  = DefWidth,
  parameter  int unsigned NUM_IN = DefNumIn,
  localparam int unsigned SEL_W  = clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    sel_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int unsigned EntryW = entry_w(WIDTH, SEL_W);

  if (NUM_IN < MinNumIn) begin : g_num_in_check
    $error("mux_n_skid: NUM_IN must be at least 2");
  end

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
    logic             err;
  } entry_n_t;

  logic [WIDTH-1:0] sel_data;
  logic             sel_bad;
  entry_n_t         in_entry, out_entry;

  // Out-of-range selects match no input, so data falls through as zero.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) sel_data = in_bus[k*WIDTH +: WIDTH];
    end
  end

  if ((32'd1 << SEL_W) == NUM_IN) begin : g_pow2
    assign sel_bad = 1'b0;
  end else begin : g_npow2
    assign sel_bad = ({1'b0, sel} >= (SEL_W+1)'(NUM_IN));
  end

  always_comb begin
    in_entry      = '0;
    in_entry.data = sel_data;
    in_entry.sel  = sel;
    in_entry.err  = sel_bad;
  end

  skid_buf #(
    .ENTRY_W (EntryW)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_entry),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_entry),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign out_data = out_entry.data;
  assign out_sel  = out_entry.sel;
  assign sel_err  = out_entry.err;

endmodule

// File: tb/tb_mux_n_skid.sv
// Bench for mux_n_skid: queue-based reference model plus directed literal checks.
module tb_mux_n_skid;

  localparam int unsigned W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // 4-input instance
  logic [4*W-1:0] bus4;
  logic [1:0]     sel4, osel4;
  logic           vld4, in_ready4, flush4, ovld4, ordy4, err4;
  logic [W-1:0]   data4;

  // 5-input instance
  logic [5*W-1:0] bus5;
  logic [2:0]     sel5, osel5;
  logic           vld5, in_ready5, flush5, ovld5, ordy5, err5;
  logic [W-1:0]   data5;

  mux_n_skid #(.WIDTH(W), .NUM_IN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_bus(bus4), .sel(sel4), .in_valid(vld4),
    .in_ready(in_ready4), .flush(flush4), .out_data(data4), .out_sel(osel4),
    .sel_err(err4), .out_valid(ovld4), .out_ready(ordy4)
  );

  mux_n_skid #(.WIDTH(W), .NUM_IN(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_bus(bus5), .sel(sel5), .in_valid(vld5),
    .in_ready(in_ready5), .flush(flush5), .out_data(data5), .out_sel(osel5),
    .sel_err(err5), .out_valid(ovld5), .out_ready(ordy5)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   sel;
    logic         err;
  } ent_t;

  ent_t q[$];
  ent_t shown;
  int   vectors = 0;
  int   miscompares = 0;
  bit   check_en = 1'b0;
  bit   m_acc, m_pop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk4(input logic [4*W-1:0] b, input logic [1:0] s);
    ent_t e;
    e.sel  = s;
    e.err  = 1'b0;
    e.data = b[int'(s)*W +: W];
    return e;
  endfunction

  function automatic logic [W-1:0] exp5(input logic [5*W-1:0] b, input logic [2:0] s);
    if (s < 3'd5) return b[int'(s)*W +: W];
    return '0;
  endfunction

  // Reference: FIFO of at most two entries; the front is what the outputs show.
  initial begin
    shown = '{data: '0, sel: '0, err: 1'b0};
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        shown = '{data: '0, sel: '0, err: 1'b0};
      end else if (flush4) begin
        q.delete();
      end else begin
        m_pop = (q.size() > 0) && ordy4;
        m_acc = vld4 && (q.size() < 2);
        if (m_pop) void'(q.pop_front());
        if (m_acc) q.push_back(mk4(bus4, sel4));
        if (q.size() > 0) shown = q[0];
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (check_en) begin
      check("out_valid", 32'(ovld4), 32'(q.size() > 0));
      check("in_ready", 32'(in_ready4), 32'(q.size() < 2));
      check("out_data", 32'(data4), 32'(shown.data));
      check("out_sel", 32'(osel4), 32'(shown.sel));
      check("sel_err", 32'(err4), 32'(shown.err));
    end
  end

  initial begin
    logic [W-1:0]   lit [4];
    logic [5*W-1:0] pb;
    logic [2:0]     ps;
    lit = '{5'h01, 5'h02, 5'h03, 5'h1F};

    bus4 = {5'h1F, 5'h03, 5'h02, 5'h01};
    sel4 = '0; vld4 = 1'b0; ordy4 = 1'b1; flush4 = 1'b0;
    bus5 = {5'h15, 5'h14, 5'h13, 5'h12, 5'h11};
    sel5 = '0; vld5 = 1'b0; ordy5 = 1'b1; flush5 = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(ovld4), 32'd0);
    check("rst_out_data", 32'(data4), 32'd0);
    check("rst_out_sel", 32'(osel4), 32'd0);
    check("rst_sel_err", 32'(err4), 32'd0);
    check("rst_out_valid5", 32'(ovld5), 32'd0);
    rst_n = 1'b1;
    check_en = 1'b1;

    // Basic select, one cycle after accept
    vld4 = 1'b1; sel4 = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("sel_data", 32'(data4), 32'(lit[i-1]));
      check("sel_valid", 32'(ovld4), 32'd1);
      check("sel_err0", 32'(err4), 32'd0);
      if (i < 4) sel4 = 2'(i);
      else vld4 = 1'b0;
    end
    @(negedge clk);

    // Backpressure: only two beats fit
    ordy4 = 1'b0; vld4 = 1'b1; sel4 = 2'd0;
    @(negedge clk);
    check("bp_ready1", 32'(in_ready4), 32'd1);
    sel4 = 2'd1;
    @(negedge clk);
    check("bp_full", 32'(in_ready4), 32'd0);
    check("bp_head", 32'(data4), 32'h01);
    sel4 = 2'd2;
    @(negedge clk);
    check("bp_still_full", 32'(in_ready4), 32'd0);
    check("bp_stable", 32'(data4), 32'h01);
    ordy4 = 1'b1; vld4 = 1'b0;
    @(negedge clk);
    check("bp_second", 32'(data4), 32'h02);
    check("bp_second_v", 32'(ovld4), 32'd1);
    check("bp_ready_back", 32'(in_ready4), 32'd1);
    @(negedge clk);
    check("bp_drained", 32'(ovld4), 32'd0);

    // Flush with both entries held and a beat offered
    ordy4 = 1'b0; vld4 = 1'b1; sel4 = 2'd3;
    @(negedge clk);
    sel4 = 2'd2;
    @(negedge clk);
    check("fl_full", 32'(in_ready4), 32'd0);
    flush4 = 1'b1; sel4 = 2'd1;
    @(negedge clk);
    check("fl_valid", 32'(ovld4), 32'd0);
    check("fl_ready", 32'(in_ready4), 32'd1);
    check("fl_data_kept", 32'(data4), 32'h1F);
    flush4 = 1'b0; vld4 = 1'b0; ordy4 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("fl_no_stale", 32'(ovld4), 32'd0);
    end

    // Non-power-of-two instance: out-of-range select
    vld5 = 1'b1; sel5 = 3'd6;
    @(negedge clk);
    check("n5_err_data", 32'(data5), 32'd0);
    check("n5_err_flag", 32'(err5), 32'd1);
    check("n5_err_sel", 32'(osel5), 32'd6);
    sel5 = 3'd4;
    @(negedge clk);
    check("n5_in4_data", 32'(data5), 32'h15);
    check("n5_in4_flag", 32'(err5), 32'd0);
    check("n5_in4_sel", 32'(osel5), 32'd4);
    for (int i = 0; i < 40; i++) begin
      pb = 25'($urandom);
      ps = 3'($urandom_range(0, 7));
      bus5 = pb; sel5 = ps;
      @(negedge clk);
      check("n5_rand_data", 32'(data5), 32'(exp5(pb, ps)));
      check("n5_rand_err", 32'(err5), 32'(ps >= 3'd5));
      check("n5_rand_sel", 32'(osel5), 32'(ps));
    end
    vld5 = 1'b0;

    // Asynchronous reset between edges while holding data
    bus4 = {5'h1F, 5'h03, 5'h02, 5'h01};
    ordy4 = 1'b0; vld4 = 1'b1; sel4 = 2'd1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(ovld4), 32'd0);
    check("ar_ready", 32'(in_ready4), 32'd1);
    check("ar_data", 32'(data4), 32'd0);
    vld4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vld4 = 1'b1; sel4 = 2'd3; ordy4 = 1'b1;
    @(negedge clk);
    check("ar_first", 32'(data4), 32'h1F);
    check("ar_first_v", 32'(ovld4), 32'd1);
    vld4 = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      vld4   = ($urandom_range(0, 99) < 60);
      ordy4  = ($urandom_range(0, 99) < 60);
      sel4   = 2'($urandom_range(0, 3));
      bus4   = 20'($urandom);
      flush4 = ($urandom_range(0, 63) == 0);
    end
    @(negedge clk);
    vld4 = 1'b0; flush4 = 1'b0; ordy4 = 1'b1;
    repeat (4) @(negedge clk);
    check_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
